mode_sequencer: RTL and testbench

MODE_SEQUENCER -- requirements
Module: mode_sequencer

---
 rtl/mode_sequencer_pkg.sv | 24 ++
 rtl/button_debounce.sv | 53 +++++
 rtl/mode_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mode_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer and the background renderer.
// Holds the sequencer state encoding, the menu-mode cursor limits and the
// width of the limit value bus driven to the mouse controller.
package mode_sequencer_pkg;

  // Stable states are StMenu and StGame; the others belong to a limit-write sequence.
  typedef enum logic [2:0] {
    StMenu,
    StWaitVbG,
    StCfgG,
    StGame,
    StWaitVbM,
    StCfgM
  } mode_state_e;

  localparam int unsigned ValueWidth = 12;

  // Menu mode lets the cursor roam the whole 1024x768 screen.
  localparam int unsigned MenuMinX = 0;
  localparam int unsigned MenuMinY = 0;
  localparam int unsigned MenuMaxX = 1023;
  localparam int unsigned MenuMaxY = 767;

endpackage

// File: rtl/button_debounce.sv
// Button conditioning: 2-flop synchronizer followed by a debounce counter.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples that disagree with it; a low-to-high flip yields a one-cycle pulse.
// Ports:
//   pclk   - clock
//   rst    - synchronous active-high reset
//   button - raw asynchronous button input
//   rise   - single-cycle pulse on an accepted rising edge
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic pclk,
  input  logic rst,
  input  logic button,
  output logic rise
);

  localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic                meta_q;
  logic                sync_q;
  logic                level_q;
  logic                rise_q;
  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q <= button;
      sync_q <= meta_q;
      rise_q <= 1'b0;
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        // This sample completes the run of DEBOUNCE_CYCLES disagreeing samples.
        level_q <= sync_q;
        rise_q  <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/mode_sequencer.sv
// Menu/game mode sequencer. Button requests (debounced) and the game-over pulse
// move between MENU and GAME; each move waits for a fresh vertical blanking rise,
// then writes the new cursor limits to the mouse controller as four one-cycle
// strobes (min_x, max_x, min_y, max_y). Mode flags switch after the last strobe.
// Ports:
//   pclk, rst                 - clock, synchronous active-high reset
//   game_button, menu_button  - raw asynchronous buttons
//   vblnk_in                  - vertical blanking, pclk domain
//   game_over_in              - one-cycle pulse forcing a return to menu
//   game_on, menu_on          - registered, mutually exclusive mode flags
//   setmin_x .. setmax_y      - limit-write strobes
//   value                     - limit value, zero when no strobe is high
//   cfg_busy                  - a mode change is in progress
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int unsigned MIN_X           = 361,
  parameter int unsigned MAX_X           = 661,
  parameter int unsigned MIN_Y           = 367,
  parameter int unsigned MAX_Y           = 667,
  parameter int unsigned MENU_MAX_X      = MenuMaxX,
  parameter int unsigned MENU_MAX_Y      = MenuMaxY,
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_button,
  input  logic        menu_button,
  input  logic        vblnk_in,
  input  logic        game_over_in,
  output logic        game_on,
  output logic        menu_on,
  output logic        setmin_x,
  output logic        setmax_x,
  output logic        setmin_y,
  output logic        setmax_y,
  output logic [11:0] value,
  output logic        cfg_busy
);

  logic game_rise;
  logic menu_rise;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_game_db (
    .pclk  (pclk),
    .rst   (rst),
    .button(game_button),
    .rise  (game_rise)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_menu_db (
    .pclk  (pclk),
    .rst   (rst),
    .button(menu_button),
    .rise  (menu_rise)
  );

  mode_state_e     state_q;
  logic [1:0]      step_q;
  logic            vb_q;
  logic            pend_game_q;
  logic            pend_menu_q;
  logic            game_on_q;
  logic            menu_on_q;
  logic [3:0]      strobe_q;  // {min_x, max_x, min_y, max_y}
  logic [11:0]     value_q;
  logic            cfg_busy_q;

  logic game_req;
  logic menu_req;
  logic vb_rise;
  logic cfg_game;

  always_comb begin
    game_req = game_rise;
    menu_req = menu_rise | game_over_in;
    vb_rise  = vblnk_in & ~vb_q;
    cfg_game = (state_q == StWaitVbG) || (state_q == StCfgG);
  end

  function automatic logic [11:0] limit_value(input logic game, input logic [1:0] idx);
    logic [11:0] v;
    unique case (idx)
      2'd0:    v = game ? 12'(MIN_X) : 12'(MenuMinX);
      2'd1:    v = game ? 12'(MAX_X) : 12'(MENU_MAX_X);
      2'd2:    v = game ? 12'(MIN_Y) : 12'(MenuMinY);
      default: v = game ? 12'(MAX_Y) : 12'(MENU_MAX_Y);
    endcase
    return v;
  endfunction

  always_ff @(posedge pclk) begin
    if (rst) begin
      // Restart straight into the menu write so the mouse limits are known.
      state_q     <= StCfgM;
      step_q      <= 2'd0;
      vb_q        <= 1'b0;
      pend_game_q <= 1'b0;
      pend_menu_q <= 1'b0;
      game_on_q   <= 1'b0;
      menu_on_q   <= 1'b1;
      strobe_q    <= 4'b0000;
      value_q     <= '0;
      cfg_busy_q  <= 1'b1;
    end else begin
      vb_q     <= vblnk_in;
      strobe_q <= 4'b0000;
      value_q  <= '0;
      unique case (state_q)
        StMenu: begin
          menu_on_q   <= 1'b1;
          game_on_q   <= 1'b0;
          pend_game_q <= 1'b0;
          pend_menu_q <= 1'b0;  // a menu request pending on arrival here is dropped
          cfg_busy_q  <= 1'b0;
          if ((game_req || pend_game_q) && !menu_req) begin
            state_q    <= StWaitVbG;
            cfg_busy_q <= 1'b1;
          end
        end
        StGame: begin
          game_on_q   <= 1'b1;
          menu_on_q   <= 1'b0;
          pend_game_q <= 1'b0;
          pend_menu_q <= 1'b0;
          cfg_busy_q  <= 1'b0;
          if (menu_req || pend_menu_q) begin
            state_q    <= StWaitVbM;
            cfg_busy_q <= 1'b1;
          end
        end
        StWaitVbG, StWaitVbM: begin
          pend_game_q <= pend_game_q | game_req;
          pend_menu_q <= pend_menu_q | menu_req;
          // The qualifying vblank edge also issues the first strobe.
          if (vb_rise) begin
            strobe_q <= 4'b1000;
            value_q  <= limit_value(cfg_game, 2'd0);
            step_q   <= 2'd1;
            state_q  <= cfg_game ? StCfgG : StCfgM;
          end
        end
        StCfgG, StCfgM: begin
          pend_game_q <= pend_game_q | game_req;
          pend_menu_q <= pend_menu_q | menu_req;
          strobe_q    <= 4'b1000 >> step_q;
          value_q     <= limit_value(cfg_game, step_q);
          step_q      <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_q <= cfg_game ? StGame : StMenu;
          end
        end
        default: begin
          state_q <= StCfgM;
          step_q  <= 2'd0;
        end
      endcase
    end
  end

  assign game_on  = game_on_q;
  assign menu_on  = menu_on_q;
  assign setmin_x = strobe_q[3];
  assign setmax_x = strobe_q[2];
  assign setmin_y = strobe_q[1];
  assign setmax_y = strobe_q[0];
  assign value    = value_q;
  assign cfg_busy = cfg_busy_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer with DEBOUNCE_CYCLES=4. Expected strobes (kind, value,
// cycle) are queued when the triggering stimulus is driven and popped by a
// monitor on the falling edge; mode flags are checked from a stimulus table.
module tb_mode_sequencer;

  logic        pclk = 1'b0;
  logic        rst;
  logic        game_button;
  logic        menu_button;
  logic        vblnk_in;
  logic        game_over_in;
  logic        game_on;
  logic        menu_on;
  logic        setmin_x;
  logic        setmax_x;
  logic        setmin_y;
  logic        setmax_y;
  logic [11:0] value;
  logic        cfg_busy;

  always #5 pclk = ~pclk;

  mode_sequencer #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .game_button (game_button),
    .menu_button (menu_button),
    .vblnk_in    (vblnk_in),
    .game_over_in(game_over_in),
    .game_on     (game_on),
    .menu_on     (menu_on),
    .setmin_x    (setmin_x),
    .setmax_x    (setmax_x),
    .setmin_y    (setmin_y),
    .setmax_y    (setmax_y),
    .value       (value),
    .cfg_busy    (cfg_busy)
  );

  typedef struct {
    logic [3:0]  strobes;
    logic [11:0] value;
    int          cyc;
  } exp_t;

  typedef struct {
    string name;
    logic  gb, mb, go, vb;
    int    hold;
    int    push;  // 0 none, 1 game limits, 2 menu limits
    logic  eg, em, eb;
  } row_t;

  exp_t sb[$];
  row_t rows[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue n strobes expected on cycles base+1 .. base+n.
  task automatic push_seq(input bit game, input int base, input int n);
    logic [11:0] v [4];
    logic [3:0]  st;
    exp_t        e;
    if (game) begin
      v[0] = 12'd361; v[1] = 12'd661; v[2] = 12'd367; v[3] = 12'd667;
    end else begin
      v[0] = 12'd0;   v[1] = 12'd1023; v[2] = 12'd0;  v[3] = 12'd767;
    end
    st = 4'b1000;
    for (int i = 0; i < n; i++) begin
      e.strobes = st;
      e.value   = v[i];
      e.cyc     = base + i + 1;
      sb.push_back(e);
      st = st >> 1;
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic wait_n(input int n);
    repeat (n) @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic add_row(input string name, input logic gb, input logic mb, input logic go,
                         input logic vb, input int hold, input int push,
                         input logic eg, input logic em, input logic eb);
    row_t r;
    r.name = name; r.gb = gb; r.mb = mb; r.go = go; r.vb = vb;
    r.hold = hold; r.push = push; r.eg = eg; r.em = em; r.eb = eb;
    rows.push_back(r);
  endtask

  always @(negedge pclk) begin : monitor
    logic [3:0] s;
    exp_t       e;
    if (mon_en) begin
      s = {setmin_x, setmax_x, setmin_y, setmax_y};
      chk("flags_exclusive", 32'(game_on ^ menu_on), 1);
      if (s == 4'b0000) begin
        chk("value_idle", 32'(value), 0);
      end else if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(s), 0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 32'(s), 32'(e.strobes));
        chk("strobe_value", 32'(value), 32'(e.value));
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  int c0;

  initial begin
    rst          = 1'b1;
    game_button  = 1'b0;
    menu_button  = 1'b0;
    vblnk_in     = 1'b0;
    game_over_in = 1'b0;

    // Reset state and the unconditional menu write after release.
    wait_n(1);
    mon_en = 1'b1;
    chk("rst_menu_on", 32'(menu_on), 1);
    chk("rst_game_on", 32'(game_on), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_strobes", 32'({setmin_x, setmax_x, setmin_y, setmax_y}), 0);
    wait_n(2);
    rst = 1'b0;
    push_seq(1'b0, cyc, 4);
    wait_n(1);
    chk("boot_busy", 32'(cfg_busy), 1);
    chk("boot_menu_on", 32'(menu_on), 1);
    wait_n(3);
    chk("boot_menu_on_last", 32'(menu_on), 1);
    wait_n(2);
    chk("boot_idle_busy", 32'(cfg_busy), 0);

    //       name             gb    mb    go    vb   hold push  eg    em    eb
    add_row("glitch",        1'b1, 1'b0, 1'b0, 1'b0,  3, 0, 1'b0, 1'b1, 1'b0);
    add_row("glitch_after",  1'b0, 1'b0, 1'b0, 1'b0, 12, 0, 1'b0, 1'b1, 1'b0);
    add_row("menu_vb_idle",  1'b0, 1'b0, 1'b0, 1'b1,  5, 0, 1'b0, 1'b1, 1'b0);
    add_row("menu_vb_low",   1'b0, 1'b0, 1'b0, 1'b0,  3, 0, 1'b0, 1'b1, 1'b0);
    add_row("game_press",    1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 1'b0, 1'b1, 1'b1);
    add_row("game_wait_vb",  1'b0, 1'b0, 1'b0, 1'b0, 20, 0, 1'b0, 1'b1, 1'b1);
    add_row("game_cfg",      1'b0, 1'b0, 1'b0, 1'b1,  4, 1, 1'b0, 1'b1, 1'b1);
    add_row("game_entered",  1'b0, 1'b0, 1'b0, 1'b1,  1, 0, 1'b1, 1'b0, 1'b0);
    add_row("game_idle",     1'b0, 1'b0, 1'b0, 1'b0,  5, 0, 1'b1, 1'b0, 1'b0);
    add_row("game_in_game",  1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 1'b1, 1'b0, 1'b0);
    add_row("game_in_game2", 1'b0, 1'b0, 1'b0, 1'b0, 20, 0, 1'b1, 1'b0, 1'b0);
    add_row("both_in_game",  1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 1'b1, 1'b0, 1'b1);
    add_row("both_release",  1'b0, 1'b0, 1'b0, 1'b0, 20, 0, 1'b1, 1'b0, 1'b1);
    add_row("menu_cfg",      1'b0, 1'b0, 1'b0, 1'b1,  4, 2, 1'b1, 1'b0, 1'b1);
    add_row("menu_entered",  1'b0, 1'b0, 1'b0, 1'b1,  1, 0, 1'b0, 1'b1, 1'b0);
    add_row("menu_idle",     1'b0, 1'b0, 1'b0, 1'b0,  3, 0, 1'b0, 1'b1, 1'b0);
    add_row("both_in_menu",  1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 1'b0, 1'b1, 1'b0);
    add_row("both_rel_menu", 1'b0, 1'b0, 1'b0, 1'b0, 20, 0, 1'b0, 1'b1, 1'b0);
    add_row("menu_vb_again", 1'b0, 1'b0, 1'b0, 1'b1,  5, 0, 1'b0, 1'b1, 1'b0);
    add_row("menu_settle",   1'b0, 1'b0, 1'b0, 1'b0,  3, 0, 1'b0, 1'b1, 1'b0);

    foreach (rows[i]) begin
      game_button  = rows[i].gb;
      menu_button  = rows[i].mb;
      game_over_in = rows[i].go;
      vblnk_in     = rows[i].vb;
      if (rows[i].push == 1) push_seq(1'b1, cyc, 4);
      else if (rows[i].push == 2) push_seq(1'b0, cyc, 4);
      wait_n(rows[i].hold);
      chk({rows[i].name, "_game_on"}, 32'(game_on), 32'(rows[i].eg));
      chk({rows[i].name, "_menu_on"}, 32'(menu_on), 32'(rows[i].em));
      chk({rows[i].name, "_busy"}, 32'(cfg_busy), 32'(rows[i].eb));
    end
    chk("table_drained", sb.size(), 0);

    // game_over during the game write: GAME is entered, then left at once.
    game_button = 1'b1;
    wait_n(10);
    game_button = 1'b0;
    wait_n(20);
    chk("go_wait_busy", 32'(cfg_busy), 1);
    vblnk_in = 1'b1;
    c0 = cyc;
    push_seq(1'b1, c0, 4);
    wait_n(1);
    game_over_in = 1'b1;
    wait_n(1);
    game_over_in = 1'b0;
    wait_n(3);
    chk("go_game_entered", 32'(game_on), 1);
    chk("go_busy_again", 32'(cfg_busy), 1);
    vblnk_in = 1'b0;
    wait_n(5);
    chk("go_game_holds", 32'(game_on), 1);
    vblnk_in = 1'b1;
    push_seq(1'b0, cyc, 4);
    wait_n(5);
    chk("go_menu_on", 32'(menu_on), 1);
    chk("go_game_off", 32'(game_on), 0);
    chk("go_idle", 32'(cfg_busy), 0);

    // vblank already high when WAIT_VB_G is entered must not start the write.
    game_button = 1'b1;
    wait_n(10);
    game_button = 1'b0;
    wait_n(20);
    chk("vbhigh_busy", 32'(cfg_busy), 1);
    chk("vbhigh_game_off", 32'(game_on), 0);
    vblnk_in = 1'b0;
    wait_n(3);

    // Reset after the second game strobe aborts the write.
    vblnk_in = 1'b1;
    c0 = cyc;
    push_seq(1'b1, c0, 2);
    wait_n(2);
    rst = 1'b1;
    wait_n(1);
    chk("abort_menu_on", 32'(menu_on), 1);
    chk("abort_game_on", 32'(game_on), 0);
    chk("abort_value", 32'(value), 0);
    wait_n(1);
    rst = 1'b0;
    push_seq(1'b0, cyc, 4);
    wait_n(1);
    chk("abort_busy", 32'(cfg_busy), 1);
    wait_n(5);
    chk("abort_menu_final", 32'(menu_on), 1);
    chk("abort_idle", 32'(cfg_busy), 0);
    chk("sb_drained", sb.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
